// File: rtl/mdu_iter.sv
//------------------------------------------------------------------------------
// mdu_iter -- iterative multiply/divide unit with built-in HI/LO registers.
//
// Produces one product or quotient bit per clock. An accepted start takes
// WIDTH+2 cycles: CALC runs for WIDTH cycles and FIX runs for one cycle.
// busy covers cycles 1..WIDTH+1. done pulses in cycle WIDTH+2, and hi/lo
// already hold the new result in that cycle. The core stalls MFHI/MFLO
// while busy is high.
//
// Optional build macro:
//   MDU_EARLY_OUT_EN -- a zero operand (or a zero divisor) skips CALC.
//                       The result is preloaded and FIX runs in cycle 1,
//                       so done pulses in cycle 2. When the macro is not
//                       defined, every operation takes the fixed latency.
//
// Ports:
//   clk          system clock
//   rst          synchronous, active-high reset; aborts any operation
//   start        operation request, accepted only while busy=0
//   op           00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   a            multiplicand / dividend (rs)
//   b            multiplier / divisor (rt)
//   wr_hi        MTHI strobe (honoured only while idle)
//   wr_lo        MTLO strobe (honoured only while idle)
//   wdata        MTHI/MTLO write data
//   busy         operation in flight
//   done         one-cycle pulse; the new HI/LO are valid in this cycle
//   div_by_zero  one-cycle pulse with done for DIV/DIVU with b==0
//   hi, lo       architectural HI and LO registers
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module mdu_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, state_nxt;

   // Operation context captured when start is accepted.
   logic [1:0]         op_r;
   logic [WIDTH-1:0]   opa_r;     // |a|, shifted out one bit per CALC cycle
   logic [WIDTH-1:0]   opb_r;     // |b|, the multiplicand or divisor
   logic [2*WIDTH-1:0] acc_r;     // product, or {remainder, quotient}
   logic [CNT_W-1:0]   cnt_r;
   logic               neg_q_r;
   logic               neg_r_r;
   logic               dbz_r;

   //---------------------------------------------------------------------------
   // Sign helpers
   //---------------------------------------------------------------------------
   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v,
                                                 input logic             en);
      return en ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg_2w(input logic [2*WIDTH-1:0] v,
                                                      input logic               en);
      return en ? -v : v;
   endfunction

   // Magnitude of a signed operand. 0x80..0 maps to itself, and that is
   // correct when the value is read as unsigned.
   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v,
                                            input logic             is_signed);
      return cond_neg(v, is_signed & v[WIDTH-1]);
   endfunction

   //---------------------------------------------------------------------------
   // Operand capture and zero detection (cycle 0)
   //---------------------------------------------------------------------------
   logic               start_ok;
   logic               sgn_in;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic               b_zero;
   logic               early;
   logic [2*WIDTH-1:0] acc_start;

   assign start_ok = start & (state == IDLE);
   assign sgn_in   = ~op[0];
   assign a_mag    = mag(a, sgn_in);
   assign b_mag    = mag(b, sgn_in);
   assign b_zero   = (b == '0);

`ifdef MDU_EARLY_OUT_EN
   logic a_zero;
   assign a_zero = (a == '0);
   // Mult and div both finish early on a zero in either operand.
   assign early  = a_zero | b_zero;
   // For a divide by zero, preload the remainder half with |a|. FIX then
   // sign-restores it to the raw a. Every other early case gives zero.
   assign acc_start = (op[1] & b_zero) ? {a_mag, {WIDTH{1'b0}}} : '0;
`else
   assign early     = 1'b0;
   assign acc_start = '0;
`endif

   //---------------------------------------------------------------------------
   // One iteration step (CALC)
   //---------------------------------------------------------------------------
   logic [WIDTH:0]     mul_sum;
   logic [2*WIDTH-1:0] acc_mul;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     div_diff;
   logic               div_ge;
   logic [2*WIDTH-1:0] acc_div;

   always_comb begin
      // Shift-add: the high half gathers partial sums and shifts right, so
      // the low half fills with the finished product bits.
      mul_sum = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                (opa_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
      acc_mul = {mul_sum, acc_r[WIDTH-1:1]};

      // Restoring division. The dividend MSB shifts into the partial
      // remainder, and a trial subtract gives one quotient bit. The
      // remainder is below the divisor, so WIDTH+1 bits cannot overflow.
      rem_sh   = {acc_r[2*WIDTH-1:WIDTH], opa_r[WIDTH-1]};
      div_diff = rem_sh - {1'b0, opb_r};
      div_ge   = ~div_diff[WIDTH];
      acc_div  = {(div_ge ? div_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                  acc_r[WIDTH-2:0], div_ge};
   end

   //---------------------------------------------------------------------------
   // Sign fix-up and result select (FIX)
   //---------------------------------------------------------------------------
   logic               fix_sgn;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   quo;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      fix_sgn = ~op_r[0];
      prod    = cond_neg_2w(acc_r, fix_sgn & neg_q_r);
      // Divide by zero forces LO to all ones. The remainder path already
      // holds |a|, and the neg_r restore turns it back into the raw a.
      quo     = dbz_r ? {WIDTH{1'b1}}
                      : cond_neg(acc_r[WIDTH-1:0], fix_sgn & neg_q_r);
      rem     = cond_neg(acc_r[2*WIDTH-1:WIDTH], fix_sgn & neg_r_r);
      res_hi  = op_r[1] ? rem : prod[2*WIDTH-1:WIDTH];
      res_lo  = op_r[1] ? quo : prod[WIDTH-1:0];
   end

   //---------------------------------------------------------------------------
   // FSM
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = early ? FIX : CALC;
         CALC:    if (cnt_r == CNT_W'(1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   //---------------------------------------------------------------------------
   // Datapath registers (no reset; they are loaded on every accepted start)
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (start_ok) begin
         op_r    <= op;
         opa_r   <= a_mag;
         opb_r   <= b_mag;
         neg_q_r <= a[WIDTH-1] ^ b[WIDTH-1];
         neg_r_r <= a[WIDTH-1];
         dbz_r   <= op[1] & b_zero;
         acc_r   <= acc_start;
         cnt_r   <= CNT_W'(WIDTH);
      end else if (state == CALC) begin
         acc_r <= op_r[1] ? acc_div : acc_mul;
         opa_r <= op_r[1] ? (opa_r << 1) : (opa_r >> 1);
         cnt_r <= cnt_r - CNT_W'(1);
      end
   end

   //---------------------------------------------------------------------------
   // Outputs and architectural HI/LO
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         hi          <= '0;
         lo          <= '0;
      end else begin
         done        <= 1'b0;
         div_by_zero <= 1'b0;
         case (state)
            IDLE: begin
               // If a start arrives with a write in the same cycle, the
               // write lands now and FIX overwrites it later.
               if (wr_hi) hi <= wdata;
               if (wr_lo) lo <= wdata;
               if (start) busy <= 1'b1;
            end
            FIX: begin
               busy        <= 1'b0;
               done        <= 1'b1;
               div_by_zero <= dbz_r;
               hi          <= res_hi;
               lo          <= res_lo;
            end
            default: ;
         endcase
      end
   end

endmodule
